// File: rtl/fp_add_sub_pipe_if.sv
// Operand/result bundle for the pipelined FP adder/subtractor.
interface fp_add_sub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic         arg_vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic [W-1:0] result;
  logic         res_vld;
  logic [3:0]   flags;

  modport master (output arg_vld, a, b, op, input result, res_vld, flags);
  modport slave  (input arg_vld, a, b, op, output result, res_vld, flags);
endinterface

// File: rtl/fp_add_sub_pipe.sv
// Parametrised 5-stage FP add/sub with RNE rounding, DAZ/FTZ and IEEE-style flags.
// Rank 0 registers the operands; ranks 1..4 are unpack/align/add/normalise; rank 5 rounds into the outputs.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  fp_add_sub_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int STAGES = 5;
  localparam int SW     = MAN_W + 4;          // hidden, frac, guard, round, sticky
  localparam int RW     = MAN_W + 2;
  localparam int LZW    = $clog2(SW + 1);
  localparam int XW     = EXP_W + LZW + 2;    // headroom so a deep left shift goes negative, not wraps
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0]    EXP_INF  = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {BYP_NONE, BYP_NAN, BYP_INF, BYP_ZERO} byp_e;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  // rank 0: operand capture
  logic [STAGES:0] vld_pipe;
  logic [W-1:0]    a_q, b_q;
  logic            op_q;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.arg_vld};
    if (bus.arg_vld) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // S1: unpack/classify; subnormals read as zero
  logic             u_sa, u_sbr, u_sb, u_za, u_zb, u_ia, u_ib, u_na, u_nb;
  logic [EXP_W-1:0] u_ea, u_eb;
  logic [MAN_W-1:0] u_fa, u_fb;

  assign {u_sa, u_ea, u_fa}  = a_q;
  assign {u_sbr, u_eb, u_fb} = b_q;
  assign u_sb = u_sbr ^ op_q;
  assign u_za = (u_ea == '0);
  assign u_zb = (u_eb == '0);
  assign u_ia = (u_ea == EXP_ONES) && (u_fa == '0);
  assign u_ib = (u_eb == EXP_ONES) && (u_fb == '0);
  assign u_na = (u_ea == EXP_ONES) && (u_fa != '0);
  assign u_nb = (u_eb == EXP_ONES) && (u_fb != '0);

  logic             s1_sa, s1_sb, s1_bs;
  byp_e             s1_byp;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;

  always_ff @(posedge clk) begin
    s1_sa <= u_sa;
    s1_sb <= u_sb;
    s1_ea <= u_ea;
    s1_eb <= u_eb;
    s1_ma <= u_za ? '0 : {1'b1, u_fa};
    s1_mb <= u_zb ? '0 : {1'b1, u_fb};
    s1_bs <= 1'b0;
    if (u_na || u_nb || (u_ia && u_ib && (u_sa != u_sb))) s1_byp <= BYP_NAN;
    else if (u_ia)          begin s1_byp <= BYP_INF;  s1_bs <= u_sa; end
    else if (u_ib)          begin s1_byp <= BYP_INF;  s1_bs <= u_sb; end
    else if (u_za && u_zb)  begin s1_byp <= BYP_ZERO; s1_bs <= u_sa & u_sb; end
    else                    s1_byp <= BYP_NONE;
  end

  // S2: order by magnitude, align smaller operand with sticky collection
  logic             a_big, x_s, y_s;
  logic [EXP_W-1:0] x_e, y_e, d;
  logic [MAN_W:0]   x_m, y_m;
  logic [2*SW-1:0]  al_wide;
  logic [SW-1:0]    y_al;

  always_comb begin
    a_big   = {s1_ea, s1_ma} >= {s1_eb, s1_mb};
    x_s     = a_big ? s1_sa : s1_sb;
    y_s     = a_big ? s1_sb : s1_sa;
    x_e     = a_big ? s1_ea : s1_eb;
    y_e     = a_big ? s1_eb : s1_ea;
    x_m     = a_big ? s1_ma : s1_mb;
    y_m     = a_big ? s1_mb : s1_ma;
    d       = x_e - y_e;
    al_wide = {y_m, 3'b000, {SW{1'b0}}} >> d;
    if (int'(d) > SW - 1) y_al = {{(SW-1){1'b0}}, |y_m};
    else                  y_al = {al_wide[2*SW-1:SW+1], al_wide[SW] | (|al_wide[SW-1:0])};
  end

  logic             s2_s, s2_sub, s2_bs;
  byp_e             s2_byp;
  logic [EXP_W-1:0] s2_e;
  logic [SW-1:0]    s2_mx, s2_my;

  always_ff @(posedge clk) begin
    s2_s   <= x_s;
    s2_sub <= x_s ^ y_s;
    s2_e   <= x_e;
    s2_mx  <= {x_m, 3'b000};
    s2_my  <= y_al;
    s2_byp <= s1_byp;
    s2_bs  <= s1_bs;
  end

  // S3: magnitude add/sub; X >= Y so the difference never goes negative
  logic             s3_s, s3_bs;
  byp_e             s3_byp;
  logic [EXP_W-1:0] s3_e;
  logic [SW:0]      s3_sum;

  always_ff @(posedge clk) begin
    s3_s   <= s2_s;
    s3_e   <= s2_e;
    s3_sum <= s2_sub ? {1'b0, s2_mx} - {1'b0, s2_my} : {1'b0, s2_mx} + {1'b0, s2_my};
    s3_byp <= s2_byp;
    s3_bs  <= s2_bs;
  end

  // S4: normalise
  logic [LZW-1:0] lz;
  logic [SW-1:0]  n_m;
  logic [XW-1:0]  n_e;

  always_comb begin
    lz = lzc(s3_sum[SW-1:0]);
    if (s3_sum[SW]) begin
      n_m = {s3_sum[SW:2], |s3_sum[1:0]};
      n_e = XW'(s3_e) + XW'(1);
    end else begin
      n_m = s3_sum[SW-1:0] << lz;
      n_e = XW'(s3_e) - XW'(lz);
    end
  end

  logic          s4_s, s4_z, s4_bs;
  byp_e          s4_byp;
  logic [XW-1:0] s4_e;
  logic [SW-1:0] s4_m;

  always_ff @(posedge clk) begin
    s4_s   <= s3_s;
    s4_z   <= (s3_sum == '0);
    s4_e   <= n_e;
    s4_m   <= n_m;
    s4_byp <= s3_byp;
    s4_bs  <= s3_bs;
  end

  // S5: round-to-nearest-even, then pack with the special/overflow/underflow overrides
  logic             g, r, st;
  logic [RW-1:0]    rnd;
  logic [XW-1:0]    r_e;
  logic [MAN_W-1:0] r_f;
  logic [W-1:0]     p_res;
  logic [3:0]       p_flg;

  always_comb begin
    g     = s4_m[2];
    r     = s4_m[1];
    st    = s4_m[0];
    rnd   = {1'b0, s4_m[SW-1:3]} + RW'(g & (r | st | s4_m[3]));
    r_e   = s4_e + XW'(rnd[MAN_W+1]);
    r_f   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    p_res = '0;
    p_flg = '0;
    case (s4_byp)
      BYP_NAN: begin
        p_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        p_flg = 4'b1000;
      end
      BYP_INF:  p_res = {s4_bs, EXP_ONES, {MAN_W{1'b0}}};
      BYP_ZERO: p_res = {s4_bs, {(W-1){1'b0}}};
      default: begin
        if (s4_z) begin
          p_res = '0;
        end else if (s4_e[XW-1] || s4_e == '0) begin
          p_res = {s4_s, {(W-1){1'b0}}};
          p_flg = 4'b0011;
        end else if (r_e >= EXP_INF) begin
          p_res = {s4_s, EXP_ONES, {MAN_W{1'b0}}};
          p_flg = 4'b0101;
        end else begin
          p_res = {s4_s, r_e[EXP_W-1:0], r_f};
          p_flg = {3'b000, g | r | st};
        end
      end
    endcase
  end

  logic [W-1:0] res_q;
  logic [3:0]   flg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (vld_pipe[STAGES-1]) begin
      res_q <= p_res;
      flg_q <= p_flg;
    end
  end

  assign bus.result  = res_q;
  assign bus.flags   = flg_q;
  assign bus.res_vld = vld_pipe[STAGES];
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Bench for fp_add_sub_pipe: directed corner cases plus a random burst with a mid-burst reset,
// checked against an exact-arithmetic single-precision model.
module tb_fp_add_sub_pipe;
  localparam int EW = 8, MW = 23, W = 1 + EW + MW;
  localparam int HEW = 5, HMW = 10, HW = 1 + HEW + HMW;
  localparam int NB = 48, RK = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_add_sub_pipe_if #(.EXP_W(EW),  .MAN_W(MW))  bus  ();
  fp_add_sub_pipe_if #(.EXP_W(HEW), .MAN_W(HMW)) hbus ();

  fp_add_sub_pipe #(.EXP_W(EW),  .MAN_W(MW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  fp_add_sub_pipe #(.EXP_W(HEW), .MAN_W(HMW)) hdut (.clk(clk), .rst(rst), .bus(hbus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Exact sum of two single-precision values, rounded once (RNE), with DAZ/FTZ and flag rules.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic         sa, sb, sgn, inx, up, na, nb, ia, ib, za, zb;
    int           ea, eb, emin, p, sh, er;
    logic [319:0] av, bv, mag, q, rem, halfv;
    sa = a[31];
    sb = b[31] ^ op;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    if (na || nb || (ia && ib && sa != sb)) return {4'b1000, 32'h7FC00000};
    if (ia) return {4'b0000, sa, 31'h7F800000};
    if (ib) return {4'b0000, sb, 31'h7F800000};
    if (za && zb) return {4'b0000, sa & sb, 31'h0};
    if (za) ea = eb;
    if (zb) eb = ea;
    av   = za ? '0 : 320'({1'b1, a[22:0]});
    bv   = zb ? '0 : 320'({1'b1, b[22:0]});
    emin = (ea < eb) ? ea : eb;
    av   = av << (ea - emin);
    bv   = bv << (eb - emin);
    if (sa == sb)    begin mag = av + bv; sgn = sa; end
    else if (av > bv) begin mag = av - bv; sgn = sa; end
    else if (bv > av) begin mag = bv - av; sgn = sb; end
    else return 36'h0;
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    er = emin + p - MW;
    if (er <= 0) return {4'b0011, sgn, 31'h0};
    inx = 1'b0;
    up  = 1'b0;
    if (p > MW) begin
      sh    = p - MW;
      q     = mag >> sh;
      rem   = mag & ((320'd1 << sh) - 320'd1);
      halfv = 320'd1 << (sh - 1);
      inx   = (rem != 0);
      up    = (rem > halfv) || (rem == halfv && q[0]);
    end else begin
      q = mag << (MW - p);
    end
    q = q + 320'(up);
    if (q[MW+1]) begin q = q >> 1; er++; end
    if (er >= 255) return {4'b0101, sgn, 31'h7F800000};
    return {3'b000, inx, sgn, 8'(er), q[22:0]};
  endfunction

  function automatic logic [31:0] gen_b(input logic [31:0] a);
    logic [31:0] b;
    b = $urandom;
    if ($urandom_range(0, 7) == 0)      b[30:0] = a[30:0];
    else if ($urandom_range(0, 1) == 1) b[30:23] = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
    return b;
  endfunction

  // One op into the selected DUT, then exact 5-cycle latency and single-cycle pulse checks.
  task automatic dir_op(input string tag, input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    if (half) begin
      hbus.a = a[HW-1:0]; hbus.b = b[HW-1:0]; hbus.op = op; hbus.arg_vld = 1'b1;
    end else begin
      bus.a = a; bus.b = b; bus.op = op; bus.arg_vld = 1'b1;
    end
    @(negedge clk);
    bus.arg_vld = 1'b0;  bus.a  = $urandom;       bus.b  = $urandom;       bus.op  = 1'($urandom);
    hbus.arg_vld = 1'b0; hbus.a = 16'($urandom);  hbus.b = 16'($urandom);  hbus.op = 1'($urandom);
    repeat (4) @(negedge clk);
    check({tag, "/early"}, 32'(half ? hbus.res_vld : bus.res_vld), 32'd0);
    @(negedge clk);
    check({tag, "/vld"}, 32'(half ? hbus.res_vld : bus.res_vld), 32'd1);
    check({tag, "/res"}, half ? 32'(hbus.result) : bus.result, er);
    check({tag, "/flg"}, 32'(half ? hbus.flags : bus.flags), 32'(ef));
    @(negedge clk);
    check({tag, "/pulse"}, 32'(half ? hbus.res_vld : bus.res_vld), 32'd0);
  endtask

  logic [NB-1:0] v_a, r_a;
  logic [31:0]   er_a [NB];
  logic [3:0]    ef_a [NB];
  logic [31:0]   held_r, ra, rb;
  logic [3:0]    held_f;
  logic [35:0]   m;
  logic          exp_v, rop, rv;

  initial begin
    // arg_vld held high through reset must not create a result
    bus.arg_vld = 1'b1;  bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0;
    hbus.arg_vld = 1'b1; hbus.a = 16'h3C00;    hbus.b = 16'h3C00;    hbus.op = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/vld", 32'(bus.res_vld), 32'd0);
    check("rst/res", bus.result, 32'd0);
    check("rst/flg", 32'(bus.flags), 32'd0);
    rst = 1'b0;
    bus.arg_vld = 1'b0;
    hbus.arg_vld = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("idle/vld", 32'(bus.res_vld), 32'd0);
    end
    check("idle/res", bus.result, 32'd0);

    dir_op("one_plus_two",  0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    dir_op("tie_odd",       0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    dir_op("tie_even",      0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    dir_op("inf_minus_inf", 0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    dir_op("overflow",      0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    dir_op("cancel",        0, 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000);
    dir_op("underflow",     0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    dir_op("negz_negz",     0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    dir_op("daz_zero",      0, 32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
    dir_op("nan_in",        0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    dir_op("neg_inf",       0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    dir_op("h_one_one",     1, 32'h3C00,     32'h3C00,     1'b0, 32'h4000,     4'b0000);
    dir_op("h_overflow",    1, 32'h7BFF,     32'h7BFF,     1'b0, 32'h7C00,     4'b0101);

    // random burst with gaps; reset lands while ops are in flight
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held_r = '0;
    held_f = '0;
    for (int k = 0; k < NB; k++) begin
      ra  = $urandom;
      rb  = gen_b(ra);
      rop = 1'($urandom);
      rv  = (k < NB - 6) && ($urandom_range(0, 3) != 0 || k == RK - 1 || k == RK - 3 || k == RK);
      rst = (k == RK);
      bus.arg_vld = rv; bus.a = ra; bus.b = rb; bus.op = rop;
      m       = ref_add(ra, rb, rop);
      v_a[k]  = rv && !rst;
      r_a[k]  = rst;
      er_a[k] = m[31:0];
      ef_a[k] = m[35:32];
      @(negedge clk);
      exp_v = 1'b0;
      if (k >= 5) begin
        exp_v = v_a[k-5];
        for (int j = k - 4; j <= k; j++) if (r_a[j]) exp_v = 1'b0;
      end
      if (r_a[k]) begin
        held_r = '0;
        held_f = '0;
      end else if (exp_v) begin
        held_r = er_a[k-5];
        held_f = ef_a[k-5];
      end
      check("burst/vld", 32'(bus.res_vld), 32'(exp_v));
      check("burst/res", bus.result, held_r);
      check("burst/flg", 32'(bus.flags), 32'(held_f));
    end
    rst = 1'b0;
    bus.arg_vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
